// File: rtl/core_local_int_if.sv
// Word-wide single-master slave bus used by core_local_int.
interface core_local_int_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [15:0] addr_i;
    logic [31:0] dat_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, addr_i, dat_i, sel_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, addr_i, dat_i, sel_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/core_local_int.sv
// Machine timer (mtime/mtimecmp) and software interrupt (msip) unit.
// Define CLINT_MTIME_WR_EN to make the mtime words writable from the bus.
module core_local_int #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    core_local_int_if.slave bus,
    output logic            xint_mtip_o,
    output logic            xint_msip_o
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          serve;
    logic          wr;
    logic [15:0]   waddr;
    logic          hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
    logic [PW-1:0] pre_q;
    logic          tick;
    logic [63:0]   mtime_q, mtime_inc, mtime_d;
    logic [63:0]   mtimecmp_q;
    logic          msip_q;
    logic [31:0]   rdata;
    logic          unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sel[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Bus FSM: one access per IDLE cycle, ACK always returns to IDLE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        serve   = 1'b0;
        case (state_q)
            S_IDLE: if (bus.cyc_i && bus.stb_i) begin
                serve   = 1'b1;
                state_d = S_ACK;
            end
            S_ACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign wr          = serve & bus.we_i;
    assign waddr       = {bus.addr_i[15:2], 2'b00};
    assign unused_addr = ^bus.addr_i[1:0];
    assign hit_msip    = (waddr == 16'h0000);
    assign hit_cmp_lo  = (waddr == 16'h4000);
    assign hit_cmp_hi  = (waddr == 16'h4004);
    assign hit_time_lo = (waddr == 16'hBFF8);
    assign hit_time_hi = (waddr == 16'hBFFC);

    assign tick      = (pre_q == PW'(TICK_DIV - 1));
    assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

`ifdef CLINT_MTIME_WR_EN
    // Written bytes override the incremented value; everything else keeps counting.
    always_comb begin
        mtime_d = mtime_inc;
        if (wr && hit_time_lo) mtime_d[31:0]  = merge_bytes(mtime_inc[31:0],  bus.dat_i, bus.sel_i);
        if (wr && hit_time_hi) mtime_d[63:32] = merge_bytes(mtime_inc[63:32], bus.dat_i, bus.sel_i);
    end
`else
    assign mtime_d = mtime_inc;
`endif

    always_comb begin
        rdata = '0;
        if (hit_msip)         rdata = {31'd0, msip_q};
        else if (hit_cmp_lo)  rdata = mtimecmp_q[31:0];
        else if (hit_cmp_hi)  rdata = mtimecmp_q[63:32];
        else if (hit_time_lo) rdata = mtime_q[31:0];
        else if (hit_time_hi) rdata = mtime_q[63:32];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q       <= '0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            msip_q      <= 1'b0;
            bus.ack_o   <= 1'b0;
            bus.dat_o   <= '0;
            xint_mtip_o <= 1'b0;
            xint_msip_o <= 1'b0;
        end else begin
            pre_q   <= tick ? '0 : pre_q + 1'b1;
            mtime_q <= mtime_d;
            if (wr && hit_cmp_lo) mtimecmp_q[31:0]  <= merge_bytes(mtimecmp_q[31:0],  bus.dat_i, bus.sel_i);
            if (wr && hit_cmp_hi) mtimecmp_q[63:32] <= merge_bytes(mtimecmp_q[63:32], bus.dat_i, bus.sel_i);
            if (wr && hit_msip && bus.sel_i[0]) msip_q <= bus.dat_i[0];
            bus.ack_o   <= serve;
            bus.dat_o   <= (serve && !bus.we_i) ? rdata : '0;
            // Interrupt lines come from pre-edge register values, hence one cycle of lag.
            xint_mtip_o <= (mtime_q >= mtimecmp_q);
            xint_msip_o <= msip_q;
        end
    end
endmodule

// File: tb/tb_core_local_int.sv
// Bench for core_local_int: TICK_DIV=4 and TICK_DIV=1 instances share one bus stimulus.
module tb_core_local_int;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        mtip4, msip4, mtip1, msip1;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    core_local_int_if bus4 ();
    core_local_int_if bus1 ();

    assign bus4.cyc_i = cyc;  assign bus1.cyc_i = cyc;
    assign bus4.stb_i = stb;  assign bus1.stb_i = stb;
    assign bus4.we_i = we;    assign bus1.we_i = we;
    assign bus4.addr_i = addr; assign bus1.addr_i = addr;
    assign bus4.dat_i = dat;  assign bus1.dat_i = dat;
    assign bus4.sel_i = sel;  assign bus1.sel_i = sel;

    core_local_int #(.TICK_DIV(4)) u_dut4 (.clk_i(clk), .rst_i(rst_n), .bus(bus4.slave),
                                           .xint_mtip_o(mtip4), .xint_msip_o(msip4));
    core_local_int #(.TICK_DIV(1)) u_dut1 (.clk_i(clk), .rst_i(rst_n), .bus(bus1.slave),
                                           .xint_mtip_o(mtip1), .xint_msip_o(msip1));

    // Reference model: index 0 is the TICK_DIV=4 instance, index 1 the TICK_DIV=1 one.
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic [31:0] m_dat  [2];
    logic        m_mtip [2];
    logic        m_msipo[2];
    logic        m_ack;
    int unsigned m_cyc;

    function automatic int unsigned div_of(int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] wd, logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~m) | (wd & m);
    endfunction

    function automatic logic [31:0] ref_read(logic [15:0] a, logic [63:0] t, logic [63:0] c, logic s);
        case ({a[15:2], 2'b00})
            16'h0000: return {31'd0, s};
            16'h4000: return c[31:0];
            16'h4004: return c[63:32];
            16'hBFF8: return t[31:0];
            16'hBFFC: return t[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        if (!rst_n) begin
            m_cyc <= 0;
            m_ack <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_time[k] <= '0; m_cmp[k] <= '1; m_msip[k] <= 1'b0;
                m_dat[k] <= '0; m_mtip[k] <= 1'b0; m_msipo[k] <= 1'b0;
            end
        end else begin
            automatic logic served;
            served = cyc && stb && !m_ack;
            m_ack <= served;
            m_cyc <= m_cyc + 1;
            for (int k = 0; k < 2; k++) begin
                automatic logic [63:0] nt;
                automatic logic [63:0] nc;
                automatic logic        nm;
                nt = ((m_cyc % div_of(k)) == div_of(k) - 1) ? m_time[k] + 64'd1 : m_time[k];
                nc = m_cmp[k];
                nm = m_msip[k];
                if (served && we) begin
                    case ({addr[15:2], 2'b00})
                        16'h0000: if (sel[0]) nm = dat[0];
                        16'h4000: nc[31:0]  = ref_merge(nc[31:0], dat, sel);
                        16'h4004: nc[63:32] = ref_merge(nc[63:32], dat, sel);
`ifdef CLINT_MTIME_WR_EN
                        16'hBFF8: nt[31:0]  = ref_merge(nt[31:0], dat, sel);
                        16'hBFFC: nt[63:32] = ref_merge(nt[63:32], dat, sel);
`endif
                        default: ;
                    endcase
                end
                m_dat[k]   <= (served && !we) ? ref_read(addr, m_time[k], m_cmp[k], m_msip[k]) : 32'd0;
                m_mtip[k]  <= (m_time[k] >= m_cmp[k]);
                m_msipo[k] <= m_msip[k];
                m_time[k]  <= nt;
                m_cmp[k]   <= nc;
                m_msip[k]  <= nm;
            end
        end
    end

    task automatic chk(string tag, int k, logic [63:0] obs, logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge clk);
            chk("ack", 0, bus4.ack_o, m_ack);   chk("ack", 1, bus1.ack_o, m_ack);
            chk("dat", 0, bus4.dat_o, m_dat[0]); chk("dat", 1, bus1.dat_o, m_dat[1]);
            chk("mtip", 0, mtip4, m_mtip[0]);   chk("mtip", 1, mtip1, m_mtip[1]);
            chk("msip", 0, msip4, m_msipo[0]);  chk("msip", 1, msip1, m_msipo[1]);
        end
    endtask

    task automatic req(logic w, logic [15:0] a, logic [31:0] d, logic [3:0] s);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; dat = d; sel = s;
    endtask

    task automatic idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(logic [15:0] a, logic [31:0] d, logic [3:0] s = 4'hF);
        req(1'b1, a, d, s); step(1); idle(); step(1);
    endtask

    task automatic rd(logic [15:0] a, output logic [31:0] r4, output logic [31:0] r1);
        req(1'b0, a, 32'd0, 4'h0); step(1);
        r4 = bus4.dat_o; r1 = bus1.dat_o;
        idle(); step(1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); step(2); rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] r4, r1;
        int guard;

        // Reset values
        do_reset();
        chk("rst_ack", 0, bus4.ack_o, 1'b0); chk("rst_ack", 1, bus1.ack_o, 1'b0);
        chk("rst_mtip", 0, mtip4, 1'b0);     chk("rst_msip", 1, msip1, 1'b0);
        rd(16'hBFF8, r4, r1); chk("rst_time_lo", 0, r4, 0); chk("rst_time_lo", 1, r1, 0);
        rd(16'hBFFC, r4, r1); chk("rst_time_hi", 0, r4, 0); chk("rst_time_hi", 1, r1, 0);
        rd(16'h4000, r4, r1); chk("rst_cmp_lo", 0, r4, 32'hFFFF_FFFF); chk("rst_cmp_lo", 1, r1, 32'hFFFF_FFFF);
        rd(16'h4004, r4, r1); chk("rst_cmp_hi", 0, r4, 32'hFFFF_FFFF); chk("rst_cmp_hi", 1, r1, 32'hFFFF_FFFF);

        // Timer interrupt on the divide-by-4 instance: mtime reaches 3 on edge 12
        do_reset();
        wr(16'h4004, 32'd0);
        wr(16'h4000, 32'd3);
        step(8);  chk("mtip_before", 0, mtip4, 1'b0);
        step(1);  chk("mtip_rise", 0, mtip4, 1'b1);
        req(1'b1, 16'h4000, 32'h100, 4'hF);
        step(1);  chk("mtip_hold", 0, mtip4, 1'b1);
        idle();
        step(1);  chk("mtip_fall", 0, mtip4, 1'b0);

        // Software interrupt
        req(1'b1, 16'h0000, 32'h1, 4'b0001);
        step(1); chk("msip_lag", 0, msip4, 1'b0);
        idle();
        step(1); chk("msip_set", 0, msip4, 1'b1); chk("msip_set", 1, msip1, 1'b1);
        req(1'b1, 16'h0000, 32'h0, 4'b0000);
        step(1); chk("sel0_ack", 1, bus1.ack_o, 1'b1);
        idle();
        step(2); chk("sel0_keep", 1, msip1, 1'b1);
        wr(16'h0000, 32'h0);
        step(1); chk("msip_clr", 0, msip4, 1'b0); chk("msip_clr", 1, msip1, 1'b0);

        // Bus protocol: held strobe is served every other cycle
        req(1'b0, 16'h4000, 32'd0, 4'h0);
        chk("hold_ack0", 1, bus1.ack_o, 1'b0);
        step(1); chk("hold_ack1", 1, bus1.ack_o, 1'b1);
        step(1); chk("hold_ack2", 1, bus1.ack_o, 1'b0);
        step(1); chk("hold_ack3", 1, bus1.ack_o, 1'b1);
        idle(); step(1);
        rd(16'h1234, r4, r1); chk("unmapped", 1, r1, 32'd0);
        wr(16'h4000, 32'h1122_3344);
        wr(16'h4000, 32'h00AB_0000, 4'b0100);
        rd(16'h4000, r4, r1); chk("byte_wr", 0, r4, 32'h11AB_3344); chk("byte_wr", 1, r1, 32'h11AB_3344);

`ifdef CLINT_MTIME_WR_EN
        // Carry into the high word, then full 64-bit wrap with mtimecmp = 0
        wr(16'hBFFC, 32'd0);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        rd(16'hBFFC, r4, r1); chk("carry_hi", 1, r1, 32'd1);
        wr(16'h4000, 32'd0);
        wr(16'h4004, 32'd0);
        wr(16'hBFFC, 32'hFFFF_FFFF);
        wr(16'hBFF8, 32'hFFFF_FFFF);
        rd(16'hBFF8, r4, r1); chk("wrap_lo", 1, r1, 32'd0); chk("wrap_mtip", 1, mtip1, 1'b1);
        rd(16'hBFFC, r4, r1); chk("wrap_hi", 1, r1, 32'd0); chk("wrap_mtip", 0, mtip4, 1'b1);
`endif

        // Write/tick collision on the divide-by-1 instance at mtime = 0x1FF
        do_reset();
        guard = 0;
        while (m_time[1] != 64'h1FF && guard < 2000) begin
            step(1);
            guard++;
        end
        chk("wait_1ff", 1, (guard < 2000), 1'b1);
        wr(16'hBFF8, 32'h10, 4'b0001);
        rd(16'hBFF8, r4, r1);
        // Read is sampled two edges after the write edge, so one more tick has landed.
`ifdef CLINT_MTIME_WR_EN
        chk("collide", 1, r1, 32'h211);
`else
        chk("collide", 1, r1, 32'h201);
`endif

        // Asynchronous reset in the middle of an access
        req(1'b1, 16'h0000, 32'h1, 4'b0001);
        step(1);
        #2 rst_n = 1'b0;
        #1 chk("async_ack", 0, bus4.ack_o, 1'b0); chk("async_ack", 1, bus1.ack_o, 1'b0);
        idle();
        step(1);
        rst_n = 1'b1;
        step(2); chk("async_msip", 1, msip1, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 300; i++) begin
            automatic logic [15:0] a;
            automatic logic [31:0] d;
            case ($urandom_range(0, 5))
                0: a = 16'h0000;
                1: a = 16'h4000;
                2: a = 16'h4004;
                3: a = 16'hBFF8;
                4: a = 16'hBFFC;
                default: a = 16'($urandom);
            endcase
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            req(1'($urandom), a | 16'($urandom_range(0, 3)), d, 4'($urandom));
            step(1);
            if ($urandom_range(0, 3) == 0) step(1);
            idle();
            step($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
